// File: rtl/add_acc_pkg.sv
// ============================================================================
// Module   : add_acc_pkg
// Purpose  : Shared FSM state type and width helpers for add_acc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_acc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  // Wide enough for ACC_LEN sums of two WIDTH-bit operands without wrapping.
  function automatic int acc_width(input int width, input int acc_len);
    return width + 1 + $clog2(acc_len);
  endfunction

  function automatic int cnt_width(input int acc_len);
    return (acc_len > 1) ? $clog2(acc_len) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_acc_oreg.sv
// ============================================================================
// Module   : add_acc_oreg
// Purpose  : Result register with valid/ready hold; a load wins over a take.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_acc_oreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ovf,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf,
  output logic             o_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (i_load) begin
      data_d  = i_data;
      ovf_d   = i_ovf;
      valid_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_ovf   = ovf_q;
  assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/add_acc.sv
// ============================================================================
// Module   : add_acc
// Purpose  : Sums ACC_LEN accepted (A+B) pairs into one registered result.
//            Define ADD_ACC_SAT_EN to saturate overflowing results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_acc
  import add_acc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic [WIDTH-1:0] DIN_A,
  input  logic [WIDTH-1:0] DIN_B,
  input  logic             CLEAR,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_OVF
);

  localparam int               ACC_W    = acc_width(WIDTH, ACC_LEN);
  localparam int               CNT_W    = cnt_width(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
  localparam logic             SINGLE   = (ACC_LEN == 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] w_total;
  logic             w_final;
  logic             w_accept;
  logic             w_load;
  logic             w_stall;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;

  assign w_total = acc_q + ACC_W'(DIN_A) + ACC_W'(DIN_B);
  // In IDLE nothing has been accumulated, so a beat is final only when ACC_LEN is 1.
  assign w_final = (state_q == IDLE) ? SINGLE : (cnt_q == LAST_CNT);
  assign w_stall = DOUT_VALID && !DOUT_READY;

  assign DIN_READY = !CLEAR && !RST && !(w_final && w_stall);
  assign w_accept  = DIN_VALID && DIN_READY;
  assign w_load    = w_accept && w_final;

  assign w_ovf = |w_total[ACC_W-1:WIDTH];
`ifdef ADD_ACC_SAT_EN
  assign w_result = w_ovf ? {WIDTH{1'b1}} : w_total[WIDTH-1:0];
`else
  assign w_result = w_total[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (CLEAR) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (w_accept) begin
      if (w_final) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = w_total;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  add_acc_oreg #(
    .WIDTH (WIDTH)
  ) u_oreg (
    .clk     (CLK),
    .rst     (RST),
    .i_load  (w_load),
    .i_data  (w_result),
    .i_ovf   (w_ovf),
    .i_ready (DOUT_READY),
    .o_data  (DOUT),
    .o_ovf   (DOUT_OVF),
    .o_valid (DOUT_VALID)
  );

endmodule

`default_nettype wire

// File: tb/tb_add_acc.sv
// ============================================================================
// Module   : tb_add_acc
// Purpose  : Scoreboard bench for add_acc (ACC_LEN=4) plus an ACC_LEN=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_acc;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din_valid = 1'b0, din_ready, clear = 1'b0;
  logic [W-1:0] din_a = '0, din_b = '0, dout;
  logic         dout_valid, dout_ready = 1'b1, dout_ovf;

  logic         s_valid = 1'b0, s_ready, s_dvalid, s_ovf;
  logic [W-1:0] s_a = '0, s_b = '0, s_dout;

  always #5 clk = ~clk;

  add_acc #(.WIDTH(W), .ACC_LEN(L)) dut (
    .CLK(clk), .RST(rst), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .DIN_A(din_a), .DIN_B(din_b), .CLEAR(clear), .DOUT_VALID(dout_valid),
    .DOUT_READY(dout_ready), .DOUT(dout), .DOUT_OVF(dout_ovf)
  );

  add_acc #(.WIDTH(W), .ACC_LEN(1)) dut1 (
    .CLK(clk), .RST(rst), .DIN_VALID(s_valid), .DIN_READY(s_ready),
    .DIN_A(s_a), .DIN_B(s_b), .CLEAR(1'b0), .DOUT_VALID(s_dvalid),
    .DOUT_READY(1'b1), .DOUT(s_dout), .DOUT_OVF(s_ovf)
  );

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_sum = 0;
  int   m_cnt = 0;
  bit   m_pend = 0;
  bit   holding = 0;
  int   hold_d;
  bit   hold_o;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_result(input int total);
    exp_t e;
    e.ovf = (total > 255);
`ifdef ADD_ACC_SAT_EN
    e.data = e.ovf ? 255 : total;
`else
    e.data = total % 256;
`endif
    sb.push_back(e);
  endfunction

  // One clock of stimulus; the model advances using the handshake seen at the edge.
  task automatic cycle(input bit v, input int a, input int b, input bit clr, input bit dr);
    bit took, fin;
    @(negedge clk);
    din_valid = v; din_a = W'(a); din_b = W'(b); clear = clr; dout_ready = dr;
    #1;
    check("din_ready", din_ready, !clr && !((m_cnt == L - 1) && m_pend && !dr));
    check("dout_valid", dout_valid, m_pend);
    took = v && din_ready;
    fin  = 0;
    @(posedge clk);
    if (clr) begin
      m_sum = 0;
      m_cnt = 0;
    end else if (took) begin
      m_sum += a + b;
      m_cnt++;
      if (m_cnt == L) begin
        push_result(m_sum);
        m_sum = 0;
        m_cnt = 0;
        fin = 1;
      end
    end
    m_pend = fin || (m_pend && !dr);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    din_valid = 0; clear = 0;
    #3 rst = 1;
    #1;
    check("rst_dout", dout, 0);
    check("rst_ovf", dout_ovf, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 0);
    sb.delete();
    m_sum = 0; m_cnt = 0; m_pend = 0; holding = 0;
    @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic single_test();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = (i < 3);
      s_a = W'(2 * i + 1);
      s_b = W'(2 * i + 2);
      #1;
      check("single_din_ready", s_ready, 1);
      if (i > 0) begin
        check("single_valid", s_dvalid, 1);
        check("single_dout", s_dout, 4 * (i - 1) + 3);
      end
    end
    @(negedge clk);
    s_valid = 0;
  endtask

  // Monitor: consumes results on handshake and verifies holds under backpressure.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        holding = 0;
      end else begin
        if (holding) begin
          check("hold_dout", dout, hold_d);
          check("hold_ovf", dout_ovf, hold_o);
          check("hold_valid", dout_valid, 1);
        end
        holding = 0;
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            check("dout", dout, e.data);
            check("dout_ovf", dout_ovf, e.ovf);
          end
        end else if (dout_valid) begin
          holding = 1;
          hold_d  = dout;
          hold_o  = dout_ovf;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pulse_reset();
    // basic sum -> 36
    cycle(1, 1, 2, 0, 1); cycle(1, 3, 4, 0, 1);
    cycle(1, 5, 6, 0, 1); cycle(1, 7, 8, 0, 1);
    cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
    // overflow -> 1200
    for (int i = 0; i < 4; i++) cycle(1, 200, 100, 0, 1);
    cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
    // backpressure: 8th beat refused until the consumer takes result 1
    for (int i = 0; i < 9; i++) cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
    // clear discards the partial sum
    cycle(1, 9, 9, 0, 1); cycle(1, 9, 9, 0, 1);
    cycle(1, 9, 9, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
    // reset with a pending result and a partial accumulation
    for (int i = 0; i < 6; i++) cycle(1, 10, 10, 0, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) cycle(1, 2, 3, 0, 1);
    cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
    single_test();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit v, clr, dr;
      int a, b;
      if (i == 400) pulse_reset();
      v   = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      dr  = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
      end else begin
        a = $urandom_range(0, 31);
        b = $urandom_range(0, 31);
      end
      cycle(v, a, b, clr, dr);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_acc.md
ADD_ACC -- requirements
Module: add_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of DIN_A, DIN_B and DOUT (>=2).
REQ-002 The block SHALL have parameter ACC_LEN, default 4: number of accepted input pairs summed per result (>=1).
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port DIN_VALID  input  1  input pair present.
REQ-006 The block SHALL have port DIN_READY  output  1  block can accept the input pair.
REQ-007 The block SHALL have port DIN_A  input  WIDTH  unsigned operand A.
REQ-008 The block SHALL have port DIN_B  input  WIDTH  unsigned operand B.
REQ-009 The block SHALL have port CLEAR  input  1  synchronous discard of the partial accumulation.
REQ-010 The block SHALL have port DOUT_VALID  output  1  result held in the output register.
REQ-011 The block SHALL have port DOUT_READY  input  1  consumer takes the result.
REQ-012 The block SHALL have port DOUT  output  WIDTH  accumulated result, registered.
REQ-013 The block SHALL have port DOUT_OVF  output  1  the result exceeded 2^WIDTH-1, registered with DOUT.

Function
REQ-014 A beat SHALL be accepted when DIN_VALID and DIN_READY are both high at a CLK edge.
REQ-015 Each accepted beat SHALL add DIN_A+DIN_B into an internal accumulator of WIDTH+1+clog2(ACC_LEN) bits, so no internal wrap occurs.
REQ-016 The FSM SHALL have two states: IDLE (count 0, accumulator 0) and ACCUM (0 < count < ACC_LEN).
- IDLE->ACCUM on an accepted non-final beat.
- ACCUM->IDLE on the final (ACC_LEN-th) accepted beat or on CLEAR.
- When ACC_LEN=1, every beat is final and the FSM stays in IDLE.
REQ-017 On a final beat, the total (accumulator + current pair) SHALL load the output register, and DOUT_VALID SHALL rise on the next edge (latency 1 cycle from final accept).
- The accumulator and count SHALL clear on that same edge.
REQ-018 DOUT, DOUT_OVF and DOUT_VALID SHALL hold stable while DOUT_VALID=1 and DOUT_READY=0.
REQ-019 DOUT_VALID SHALL clear after an edge with DOUT_READY=1, unless a new final beat loads the register on that same edge; in that case it stays high with the new value.
REQ-020 DIN_READY SHALL be low when CLEAR=1, during RST, or when the next beat would be final while DOUT_VALID=1 and DOUT_READY=0; otherwise it SHALL be high.
- Non-final beats are accepted even while the output is stalled.
REQ-021 CLEAR SHALL zero the accumulator and count, return the FSM to IDLE, and leave the output register and DOUT_VALID untouched.
REQ-022 DOUT_OVF SHALL be 1 exactly when the full-width total exceeds 2^WIDTH-1.
REQ-023 Back-to-back final beats with DOUT_READY held high SHALL sustain one result per cycle.

Reset
REQ-024 Asserting RST SHALL immediately force the following, regardless of CLK:
- DOUT=0, DOUT_OVF=0, DOUT_VALID=0;
- accumulator=0, count=0, FSM=IDLE.
REQ-025 A reset asserted mid-accumulation or with a pending output SHALL discard both.
- The first result after reset SHALL contain only beats accepted after RST deasserts.

Configuration
REQ-026 With ADD_ACC_SAT_EN defined, an overflowing result SHALL drive DOUT to all ones (2^WIDTH-1) and DOUT_OVF=1.
REQ-027 Without ADD_ACC_SAT_EN, an overflowing result SHALL drive DOUT to the total modulo 2^WIDTH, with DOUT_OVF still 1.

Structure
REQ-028 A shared package add_acc_pkg SHALL hold the following:
- the FSM state type (IDLE, ACCUM);
- a function returning the accumulator width from WIDTH and ACC_LEN.
REQ-029 The output register with its valid/ready hold logic SHALL be a sub-module add_acc_oreg, parametrised by WIDTH.

Verification (WIDTH=8, ACC_LEN=4 unless stated)
REQ-030 Basic sum: pairs (1,2),(3,4),(5,6),(7,8), DOUT_READY=1 -> DOUT=36, DOUT_OVF=0, DOUT_VALID high one cycle after the 4th accept.
REQ-031 Overflow: four pairs (200,100), total 1200 -> DOUT_OVF=1; DOUT=255 with ADD_ACC_SAT_EN, DOUT=176 without.
REQ-032 Backpressure: DOUT_READY=0, eight beats of (1,1) offered.
- The first result DOUT=8 is held.
- Beats 5-7 are accepted; DIN_READY=0 on beat 8 until DOUT_READY pulses.
- The second result DOUT=8 follows.
REQ-033 CLEAR: two beats of (9,9), then CLEAR for one cycle (DIN_READY=0 during it), then four beats of (1,1) -> DOUT=8.
REQ-034 Reset mid-operation: RST pulsed after two beats of (10,10) with a result pending.
- All outputs go 0 immediately.
- Four subsequent beats of (2,3) -> DOUT=20.
REQ-035 ACC_LEN=1: continuous pairs (1,2),(3,4),(5,6), DOUT_READY=1 -> DOUT=3,7,11 on consecutive cycles, DIN_READY constantly 1.
